// File: rtl/sample_uart_pkg.sv
// Shared types and constants for the sample UART transmitter.
//   uart_state_e : transmitter FSM states (StParity exists only when
//                  SAMPLE_UART_PARITY_EN is defined)
//   DATA_BITS    : serial payload width
//   cnt_width()  : bits needed to hold a counter ranging over 0..n-1
package sample_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef SAMPLE_UART_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;
`endif

  // Never returns less than one bit so degenerate ranges still get a real vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_uart_tx_if.sv
// Sample stream plus serial-side status for the sample UART transmitter.
//   in_data  : 8-bit sample from the upstream filter
//   in_valid : one-cycle strobe qualifying in_data
//   tx       : serial line, idle high
//   busy     : frame in progress or samples buffered
//   overflow : sticky, a sample was dropped
// master = upstream producer / observer, slave = transmitter.
interface sample_uart_tx_if;
  import sample_uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 tx;
  logic                 busy;
  logic                 overflow;

  modport master (
    output in_data,
    output in_valid,
    input  tx,
    input  busy,
    input  overflow
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output tx,
    output busy,
    output overflow
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO buffering samples ahead of the serialiser.
// First-word fall-through: o_rdata always shows the head entry.
//   i_clk, i_rst    : clock, synchronous active-low reset
//   i_push, i_wdata : write request and data (ignored when no space after a same-cycle pop)
//   i_pop           : remove head entry (ignored when empty)
//   o_rdata         : head entry
//   o_full, o_empty : occupancy flags
//   o_count         : number of stored entries
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
  import sample_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = cnt_width(FIFO_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned AddrW = cnt_width(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A full FIFO can still accept a write in the cycle its head is popped.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/sample_uart_tx.sv
// Buffered UART transmitter for filtered samples: 8N1 frames, LSB first.
//   i_clk  : clock, all logic on the rising edge
//   i_rst  : synchronous active-low reset
//   io_bus : sample_uart_tx_if.slave (in_data/in_valid in, tx/busy/overflow out)
// Build option SAMPLE_UART_PARITY_EN adds an even-parity bit after the data bits.
// All outputs are registered; tx lags the FSM state by one cycle, which gives a
// two-edge latency from an accepted sample to the start bit when idle.
module sample_uart_tx
  import sample_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  sample_uart_tx_if.slave io_bus
);

  localparam int unsigned BaudW    = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BitW     = cnt_width(DATA_BITS);
  localparam int unsigned FifoCntW = cnt_width(FIFO_DEPTH + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [BaudW-1:0]     r_baud;
  logic [BitW-1:0]      r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_overflow;
`ifdef SAMPLE_UART_PARITY_EN
  logic                 r_par;
`endif

  logic                 w_baud_end;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [FifoCntW-1:0]  w_count;
  logic [DATA_BITS-1:0] w_rdata;

  assign w_baud_end = (r_baud == BaudLast);

  // Pop when idle, or exactly as the stop bit ends, so frames run back-to-back.
  assign w_pop = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_baud_end));

  // Space is judged after any same-cycle pop.
  assign w_push = io_bus.in_valid && (!w_full || w_pop);
  assign w_drop = io_bus.in_valid && w_full && !w_pop;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS),
    .CNT_W      (FifoCntW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (io_bus.in_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
`ifdef SAMPLE_UART_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state != StIdle) || (w_count != '0);
      if (w_drop) r_overflow <= 1'b1;

      unique case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rdata;
`ifdef SAMPLE_UART_PARITY_EN
            r_par   <= ^w_rdata;
`endif
            r_baud  <= '0;
            r_state <= StStart;
          end
        end

        StStart: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= StData;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end

        StData: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BitLast) begin
`ifdef SAMPLE_UART_PARITY_EN
              r_state <= StParity;
`else
              r_state <= StStop;
`endif
            end else begin
              r_bit <= r_bit + BitW'(1);
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end

`ifdef SAMPLE_UART_PARITY_EN
        StParity: begin
          r_tx <= r_par;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= StStop;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
`endif

        StStop: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_rdata;
`ifdef SAMPLE_UART_PARITY_EN
              r_par   <= ^w_rdata;
`endif
              r_state <= StStart;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_baud  <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.tx       = r_tx;
  assign io_bus.busy     = r_busy;
  assign io_bus.overflow = r_overflow;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Each scenario is a per-cycle table of inputs and expected tx/busy/overflow,
// indexed by the rising edge after which the outputs are sampled.
module tb_sample_uart_tx;

  localparam int Cpb       = 4;
  localparam int FifoDepth = 4;
`ifdef SAMPLE_UART_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameCyc = FrameBits * Cpb;
  localparam int MaxCyc   = 400;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sample_uart_tx_if u_if ();

  sample_uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (FifoDepth)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_bus (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc;

  logic       sv_valid [MaxCyc];
  logic [7:0] sv_data  [MaxCyc];
  logic       sv_rst   [MaxCyc];
  logic       ex_tx    [MaxCyc];
  logic       ex_busy  [MaxCyc];
  logic       ex_ovf   [MaxCyc];

  vec_t vecs [6];

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %b want %b", nm, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for three edges with a valid sample presented that must be ignored.
  task automatic do_reset();
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset.tx", i, u_if.tx, 1'b1);
      chk("reset.busy", i, u_if.busy, 1'b0);
      chk("reset.ovf", i, u_if.overflow, 1'b0);
    end
    rst_n         = 1'b1;
    u_if.in_valid = 1'b0;
    tick();
    chk("post_reset.busy", 3, u_if.busy, 1'b0);
    chk("post_reset.tx", 3, u_if.tx, 1'b1);
  endtask

  task automatic clear_scn(input int n);
    n_cyc = n;
    for (int k = 0; k < MaxCyc; k++) begin
      sv_valid[k] = 1'b0;
      sv_data[k]  = 8'($urandom);
      sv_rst[k]   = 1'b1;
      ex_tx[k]    = 1'b1;
      ex_busy[k]  = 1'b0;
      ex_ovf[k]   = 1'b0;
    end
  endtask

  task automatic push_at(input int k, input logic [7:0] d);
    sv_valid[k] = 1'b1;
    sv_data[k]  = d;
  endtask

  // Frame on the line starting at cycle c0: start, data LSB first, [parity], stop.
  task automatic add_frame(input int c0, input logic [7:0] d, input logic p);
    logic [10:0] fr;
    fr = {1'b1, p, d, 1'b0};
`ifndef SAMPLE_UART_PARITY_EN
    fr[9] = 1'b1;
`endif
    for (int i = 0; i < FrameBits; i++)
      for (int j = 0; j < Cpb; j++) ex_tx[c0 + i * Cpb + j] = fr[i];
    for (int k = c0 - 1; k < c0 + FrameCyc; k++) ex_busy[k] = 1'b1;
  endtask

  task automatic run_scn(input string nm);
    for (int k = 0; k < n_cyc; k++) begin
      u_if.in_valid = sv_valid[k];
      u_if.in_data  = sv_data[k];
      rst_n         = sv_rst[k];
      tick();
      chk($sformatf("%s.tx", nm), k, u_if.tx, ex_tx[k]);
      chk($sformatf("%s.busy", nm), k, u_if.busy, ex_busy[k]);
      chk($sformatf("%s.ovf", nm), k, u_if.overflow, ex_ovf[k]);
    end
    u_if.in_valid = 1'b0;
    rst_n         = 1'b1;
  endtask

  initial begin
    logic [4:0] burst_par;
    logic [7:0] full_dat [6];
    logic [5:0] full_par;

    rst_n         = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h01, par: 1'b1};
    vecs[2] = '{data: 8'h00, par: 1'b0};
    vecs[3] = '{data: 8'hFF, par: 1'b0};
    vecs[4] = '{data: 8'h3C, par: 1'b0};
    vecs[5] = '{data: 8'h80, par: 1'b1};

    do_reset();

    // Single sample into an idle block; tx falls two edges after the accept edge.
    for (int v = 0; v < 6; v++) begin
      clear_scn(FrameCyc + 6);
      push_at(0, vecs[v].data);
      add_frame(2, vecs[v].data, vecs[v].par);
      run_scn($sformatf("single%0d", v));
    end

    // Six consecutive strobes into a depth-4 FIFO: the sixth is dropped.
    do_reset();
    burst_par = 5'b01001;  // bit f = parity of 0x10+f
    clear_scn(2 + 5 * FrameCyc + 4);
    for (int i = 0; i < 6; i++) push_at(i, 8'h10 + 8'(i));
    for (int f = 0; f < 5; f++) add_frame(2 + f * FrameCyc, 8'h10 + 8'(f), burst_par[f]);
    for (int k = 5; k < MaxCyc; k++) ex_ovf[k] = 1'b1;
    run_scn("burst");

    // FIFO full as the stop bit ends: a strobe on the pop edge is accepted.
    do_reset();
    full_dat[0] = 8'h5A; full_dat[1] = 8'hC3; full_dat[2] = 8'h07;
    full_dat[3] = 8'h81; full_dat[4] = 8'h7F; full_dat[5] = 8'hE2;
    full_par    = 6'b010100;
    clear_scn(2 + 6 * FrameCyc + 4);
    for (int i = 0; i < 5; i++) push_at(i, full_dat[i]);
    push_at(1 + FrameCyc, full_dat[5]);
    for (int f = 0; f < 6; f++) add_frame(2 + f * FrameCyc, full_dat[f], full_par[f]);
    run_scn("full_pop");

    // One-cycle reset during data bit 3 of 0xFF with two more samples queued.
    do_reset();
    clear_scn(80);
    push_at(0, 8'hFF);
    push_at(1, 8'h11);
    push_at(2, 8'h22);
    add_frame(2, 8'hFF, 1'b0);
    for (int k = 2 + FrameCyc; k < 2 + FrameCyc + 1; k++) ex_busy[k] = 1'b1;
    sv_rst[18] = 1'b0;
    for (int k = 18; k < MaxCyc; k++) begin
      ex_tx[k]   = 1'b1;
      ex_busy[k] = 1'b0;
    end
    run_scn("mid_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
